// File: rtl/riscv_run_ctrl_pkg.sv
// Shared types and helpers for the riscv run controller: FSM state encoding,
// default pass/fail signatures and a saturating increment.
package riscv_run_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_e;

  localparam logic [31:0] DEF_PASS_SIG = 32'h600D_600D;
  localparam logic [31:0] DEF_FAIL_SIG = 32'hBAD0_BAD0;

  // Callers zero-extend into 64 bits and pass their own all-ones ceiling.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input logic [63:0] max_value);
    return (value >= max_value) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/riscv_run_ctrl_sigmon.sv
// Write-back signature monitor: combinational pass/fail/timeout decode and,
// when RISCV_RUN_CTRL_CHECKSUM_EN is defined, a rotate-xor write-back checksum.
module riscv_run_ctrl_sigmon
  import riscv_run_ctrl_pkg::*;
#(
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       CNT_W          = 16,
  parameter int unsigned       TIMEOUT_CYCLES = 80,
  parameter logic [DATA_W-1:0] PASS_SIG       = DATA_W'(DEF_PASS_SIG),
  parameter logic [DATA_W-1:0] FAIL_SIG       = DATA_W'(DEF_FAIL_SIG)
) (
`ifdef RISCV_RUN_CTRL_CHECKSUM_EN
  input  logic              clk,
  input  logic              reset,
  input  logic              accept_i,
  output logic [DATA_W-1:0] wb_checksum_o,
`endif
  input  logic              wb_valid_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [CNT_W-1:0]  cycle_count_i,
  output logic              pass_hit_o,
  output logic              fail_hit_o,
  output logic              timeout_hit_o
);

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  // FAIL is decoded first so identical signatures resolve to a failure.
  assign fail_hit_o    = wb_valid_i && (wb_data_i == FAIL_SIG);
  assign pass_hit_o    = wb_valid_i && (wb_data_i == PASS_SIG) && !fail_hit_o;
  assign timeout_hit_o = (TIMEOUT_CYCLES != 0) && (cycle_count_i == TO_LAST);

`ifdef RISCV_RUN_CTRL_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;
  logic [DATA_W-1:0] checksum_d;

  assign checksum_d    = {checksum_q[DATA_W-2:0], checksum_q[DATA_W-1]} ^ wb_data_i;
  assign wb_checksum_o = checksum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (accept_i) begin
      checksum_q <= checksum_d;
    end
  end
`endif

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller for the riscv core: sequences core reset, counts RUN cycles,
// watches write-back for pass/fail signatures and enforces a timeout.
// Optional checksum output enabled by defining RISCV_RUN_CTRL_CHECKSUM_EN.
module riscv_run_ctrl
  import riscv_run_ctrl_pkg::*;
#(
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       CNT_W          = 16,
  parameter int unsigned       RST_CYCLES     = 2,
  parameter int unsigned       TIMEOUT_CYCLES = 80,
  parameter logic [DATA_W-1:0] PASS_SIG       = DATA_W'(DEF_PASS_SIG),
  parameter logic [DATA_W-1:0] FAIL_SIG       = DATA_W'(DEF_FAIL_SIG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] wb_data,
  output logic              core_reset,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  wb_count,
  output logic [DATA_W-1:0] last_wb_data
`ifdef RISCV_RUN_CTRL_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] wb_checksum
`endif
);

  localparam int unsigned HOLD_W = (RST_CYCLES < 1) ? 1 : $clog2(RST_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((RST_CYCLES < 1) ? 0 : RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONES  = '1;

  if (RST_CYCLES < 1) begin : g_chk_rst
    $error("riscv_run_ctrl: RST_CYCLES must be at least 1");
  end
  if ((TIMEOUT_CYCLES >> CNT_W) != 0) begin : g_chk_to
    $error("riscv_run_ctrl: TIMEOUT_CYCLES does not fit in CNT_W bits");
  end

  run_state_e        state_q;
  logic [HOLD_W-1:0] hold_q;
  logic              core_reset_q, running_q, done_q, pass_q, timeout_q;
  logic [CNT_W-1:0]  cycle_q, wb_cnt_q;
  logic [CNT_W-1:0]  cycle_d, wb_cnt_d;
  logic [DATA_W-1:0] last_wb_q;
  logic              pass_hit, fail_hit, timeout_hit;

  assign cycle_d  = CNT_W'(sat_inc(64'(cycle_q), 64'(CNT_ONES)));
  assign wb_cnt_d = CNT_W'(sat_inc(64'(wb_cnt_q), 64'(CNT_ONES)));

`ifdef RISCV_RUN_CTRL_CHECKSUM_EN
  riscv_run_ctrl_sigmon #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .PASS_SIG(PASS_SIG), .FAIL_SIG(FAIL_SIG)
  ) u_sigmon (
    .clk           (clk),
    .reset         (reset),
    .accept_i      ((state_q == RUN) && wb_valid),
    .wb_checksum_o (wb_checksum),
    .wb_valid_i    (wb_valid),
    .wb_data_i     (wb_data),
    .cycle_count_i (cycle_q),
    .pass_hit_o    (pass_hit),
    .fail_hit_o    (fail_hit),
    .timeout_hit_o (timeout_hit)
  );
`else
  riscv_run_ctrl_sigmon #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .PASS_SIG(PASS_SIG), .FAIL_SIG(FAIL_SIG)
  ) u_sigmon (
    .wb_valid_i    (wb_valid),
    .wb_data_i     (wb_data),
    .cycle_count_i (cycle_q),
    .pass_hit_o    (pass_hit),
    .fail_hit_o    (fail_hit),
    .timeout_hit_o (timeout_hit)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HOLD;
      hold_q       <= '0;
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      cycle_q      <= '0;
      wb_cnt_q     <= '0;
      last_wb_q    <= '0;
    end else begin
      unique case (state_q)
        HOLD: begin
          hold_q <= hold_q + HOLD_W'(1);
          if (hold_q == HOLD_LAST) begin
            state_q      <= RUN;
            core_reset_q <= 1'b0;
            running_q    <= 1'b1;
          end
        end
        RUN: begin
          // The terminating edge still counts, so counters include that cycle.
          cycle_q <= cycle_d;
          if (wb_valid) begin
            wb_cnt_q  <= wb_cnt_d;
            last_wb_q <= wb_data;
          end
          if (pass_hit || fail_hit || timeout_hit) begin
            state_q      <= DONE;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b1;
            pass_q       <= pass_hit;
            timeout_q    <= timeout_hit && !pass_hit && !fail_hit;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: state_q <= HOLD;
      endcase
    end
  end

  assign core_reset   = core_reset_q;
  assign running      = running_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign cycle_count  = cycle_q;
  assign wb_count     = wb_cnt_q;
  assign last_wb_data = last_wb_q;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Directed testbench for riscv_run_ctrl with default parameters: reset
// sequencing, pass/fail/timeout termination, freezing in DONE and mid-run reset.
module tb_riscv_run_ctrl;

  localparam logic [31:0] PASS_V = 32'h600D_600D;
  localparam logic [31:0] BAD_V  = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_data = '0;
  logic        core_reset, running, done, pass, timeout;
  logic [15:0] cycle_count, wb_count;
  logic [31:0] last_wb_data;
`ifdef RISCV_RUN_CTRL_CHECKSUM_EN
  logic [31:0] wb_checksum;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  riscv_run_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .core_reset   (core_reset),
    .running      (running),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .cycle_count  (cycle_count),
    .wb_count     (wb_count),
    .last_wb_data (last_wb_data)
`ifdef RISCV_RUN_CTRL_CHECKSUM_EN
    ,
    .wb_checksum  (wb_checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wb(input logic [31:0] data);
    wb_valid = 1'b1;
    wb_data  = data;
    tick();
    wb_valid = 1'b0;
    wb_data  = '0;
  endtask

  task automatic chk_reset(input string tag);
    $display("%s: check reset state", tag);
    check1({tag, ".core_reset"}, core_reset, 1'b1);
    check1({tag, ".running"}, running, 1'b0);
    check1({tag, ".done"}, done, 1'b0);
    check1({tag, ".pass"}, pass, 1'b0);
    check1({tag, ".timeout"}, timeout, 1'b0);
    checkw({tag, ".cycle_count"}, 64'(cycle_count), 64'd0);
    checkw({tag, ".wb_count"}, 64'(wb_count), 64'd0);
    checkw({tag, ".last_wb_data"}, 64'(last_wb_data), 64'd0);
`ifdef RISCV_RUN_CTRL_CHECKSUM_EN
    checkw({tag, ".wb_checksum"}, 64'(wb_checksum), 64'd0);
`endif
  endtask

  task automatic chk_status(input string tag, input logic e_done, input logic e_pass,
                            input logic e_to, input logic [15:0] e_cyc, input logic [15:0] e_wbc);
    $display("%s: done=%0b pass=%0b timeout=%0b cycle_count=%0d wb_count=%0d",
             tag, done, pass, timeout, cycle_count, wb_count);
    check1({tag, ".done"}, done, e_done);
    check1({tag, ".pass"}, pass, e_pass);
    check1({tag, ".timeout"}, timeout, e_to);
    check1({tag, ".core_reset"}, core_reset, e_done);
    check1({tag, ".running"}, running, !e_done);
    checkw({tag, ".cycle_count"}, 64'(cycle_count), 64'(e_cyc));
    checkw({tag, ".wb_count"}, 64'(wb_count), 64'(e_wbc));
  endtask

  // Reset pulse of one cycle, then the two HOLD cycles; leaves DUT at RUN cycle 0.
  task automatic restart(input string tag);
    reset = 1'b1;
    tick();
    chk_reset(tag);
    reset = 1'b0;
    idle(2);
    check1({tag, ".run_entry"}, running, 1'b1);
  endtask

  initial begin
    // Test 1: reset for 3 cycles, then exactly 2 cycles of core_reset.
    tick();
    chk_reset("t1_rst1");
    idle(2);
    chk_reset("t1_rst3");
    reset = 1'b0;
    tick();
    check1("t1_hold1.core_reset", core_reset, 1'b1);
    check1("t1_hold1.running", running, 1'b0);
    tick();
    chk_status("t1_run0", 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);

    // Test 2: write-backs on RUN cycles 2 and 4, PASS on cycle 10.
    idle(2);
    wb(32'h1);
    idle(1);
    wb(32'h3);
    chk_status("t2_mid", 1'b0, 1'b0, 1'b0, 16'd5, 16'd2);
    checkw("t2_mid.last_wb_data", 64'(last_wb_data), 64'h3);
    idle(5);
    wb(PASS_V);
    chk_status("t2_pass", 1'b1, 1'b1, 1'b0, 16'd11, 16'd3);
    checkw("t2_pass.last_wb_data", 64'(last_wb_data), 64'h600D600D);
`ifdef RISCV_RUN_CTRL_CHECKSUM_EN
    // 0 -> rotl(0)^1=1 -> rotl(1)^3=1 -> rotl(1)^600D600D = 600D600F
    checkw("t2_pass.wb_checksum", 64'(wb_checksum), 64'h600D600F);
`endif
    for (int i = 0; i < 5; i++) begin
      wb(BAD_V);
      chk_status("t2_frozen", 1'b1, 1'b1, 1'b0, 16'd11, 16'd3);
      checkw("t2_frozen.last_wb_data", 64'(last_wb_data), 64'h600D600D);
    end

    // Test 3: FAIL signature on RUN cycle 5.
    restart("t3_rst");
    idle(5);
    wb(BAD_V);
    chk_status("t3_fail", 1'b1, 1'b0, 1'b0, 16'd6, 16'd1);
    checkw("t3_fail.last_wb_data", 64'(last_wb_data), 64'hBAD0BAD0);

    // Test 4: timeout after 80 RUN cycles; later PASS pulses are ignored.
    restart("t4_rst");
    idle(79);
    chk_status("t4_pre", 1'b0, 1'b0, 1'b0, 16'd79, 16'd0);
    idle(1);
    chk_status("t4_timeout", 1'b1, 1'b0, 1'b1, 16'd80, 16'd0);
    for (int i = 0; i < 3; i++) begin
      wb(PASS_V);
      chk_status("t4_frozen", 1'b1, 1'b0, 1'b1, 16'd80, 16'd0);
      checkw("t4_frozen.last_wb_data", 64'(last_wb_data), 64'd0);
    end

    // Test 5: PASS on the timeout cycle wins over timeout.
    restart("t5_rst");
    idle(79);
    wb(PASS_V);
    chk_status("t5_pass_at_to", 1'b1, 1'b1, 1'b0, 16'd80, 16'd1);

    // Test 6: reset asserted at RUN cycle 20.
    restart("t6_rst");
    idle(3);
    wb(32'h55);
    idle(16);
    chk_status("t6_c20", 1'b0, 1'b0, 1'b0, 16'd20, 16'd1);
    checkw("t6_c20.last_wb_data", 64'(last_wb_data), 64'h55);
    reset = 1'b1;
    tick();
    chk_reset("t6_midrun_rst");
    reset = 1'b0;
    tick();
    check1("t6_hold1.core_reset", core_reset, 1'b1);
    check1("t6_hold1.running", running, 1'b0);
    tick();
    chk_status("t6_run0", 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    idle(1);
    chk_status("t6_run1", 1'b0, 1'b0, 1'b0, 16'd1, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
